tag_pool_arbiter: RTL and testbench
===================================

Name: tag_pool_arbiter

Overview:
Controller that shares one tag free-list (a fifo_init instance preloaded with tags INIT_VAL..INIT_VAL+DEPTH-1) among NUM_REQ allocation requesters and NUM_RET return ports. It waits for the pool to finish its initialisation, then pops tags under round-robin arbitration and hands each one to the winning requester. It merges returned tags back into the pool under fixed priority. It also tracks the outstanding-tag count and flags spurious returns.

Parameters:
NUM_REQ, 4, number of allocation requesters (>=2)
NUM_RET, 2, number of tag return ports (>=1)
TAG_WIDTH, 2, tag width; equals the pool DATA_WIDTH
DEPTH, 4, pool depth; equals the maximum number of outstanding tags

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
i__alloc_req  in  NUM_REQ  per-requester allocation request (level)
o__alloc_grant  out  NUM_REQ  registered one-hot grant; valid for 1 cycle
o__alloc_tag  out  TAG_WIDTH  registered tag; qualified by any bit of o__alloc_grant
i__ret_valid  in  NUM_RET  return valid per port
i__ret_tag  in  NUM_RET*TAG_WIDTH  returned tags; port k occupies bits [k*TAG_WIDTH +: TAG_WIDTH]
o__ret_ready  out  NUM_RET  return accepted
i__pool_out_valid  in  1  pool output valid
i__pool_out  in  TAG_WIDTH  pool head tag
o__pool_out_ready  out  1  pop pool
o__pool_in_valid  out  1  push to pool
o__pool_in  out  TAG_WIDTH  tag pushed to pool
i__pool_in_ready  in  1  pool can accept
o__ready  out  1  arbiter is in ACTIVE
o__outstanding  out  $clog2(DEPTH+1)  number of tags currently allocated
o__err_spurious_ret  out  1  sticky error flag

Behaviour:
- Reset applies only at a clk edge with reset=1. Reset values: state=WAIT_INIT, grant=0, tag=0, rr pointer=0, outstanding=0, err=0. All pool and return handshake outputs are 0 while in WAIT_INIT.
- Reset mid-operation: everything returns to WAIT_INIT. In-flight grants and counts are discarded. The pool shares the same reset and re-initialises.
- FSM WAIT_INIT -> ACTIVE at the first cycle with i__pool_out_valid=1. No pop happens in that cycle. There is no other transition except reset. o__ready = (state==ACTIVE).
- Allocation, in ACTIVE:
  - Eligible requesters = i__alloc_req & ~o__alloc_grant. A requester holding its grant this cycle is masked.
  - If any requester is eligible and i__pool_out_valid=1: pick the first eligible index at or after rr pointer, wrapping modulo NUM_REQ. Assert o__pool_out_ready=1 that cycle.
  - Next cycle: o__alloc_grant = onehot(winner) and o__alloc_tag = i__pool_out sampled at the pop. The rr pointer becomes (winner+1) mod NUM_REQ.
  - Otherwise the next grant is 0, and o__alloc_tag holds its last value.
  - Latency from request to grant: 1 cycle.
  - A requester must drop its request in the cycle its grant is visible, or it re-arbitrates from the following cycle.
  - When the pool is empty (i__pool_out_valid=0) there is no pop and no grant. Requests wait.
- Return, in ACTIVE:
  - Fixed priority, lowest index wins; at most one return per cycle.
  - o__pool_in_valid = selected port's valid, gated by outstanding>0.
  - o__pool_in = the selected port's tag, passed through combinationally.
  - o__ret_ready[k] = 1 only for the selected port k, when i__pool_in_ready=1 and outstanding>0.
  - Non-selected ports see ready=0 and must hold valid and tag.
- Outstanding counter:
  - +1 on a pop (pool_out_valid & pool_out_ready).
  - -1 on a return handshake.
  - Both in the same cycle: unchanged.
  - Cannot exceed DEPTH, because a pop needs pool data.
- Spurious return: any i__ret_valid=1 in ACTIVE while outstanding==0 sets err=1 and accepts no handshake. err is sticky until reset.
- Tag values are not checked (duplicate detection is out of scope).

Test Plan:
Every scenario uses the pool fifo_init with DEPTH=4, INIT_VAL=0, so the pool holds tags 0,1,2,3.
1. Release reset with no requests -> o__ready=0 and all handshake outputs 0 until the pool asserts out_valid (about 4-5 cycles later). Then o__ready=1 and o__outstanding=0.
2. Hold i__alloc_req=4'b0001 continuously -> grants 4'b0001 on alternate cycles with tags 0,1,2,3. o__outstanding reaches 4. After that, o__pool_out_ready=0 and no further grants.
3. From a fresh init, assert i__alloc_req=4'b1111 for 4 cycles -> back-to-back grants 0001,0010,0100,1000 with tags 0,1,2,3 on consecutive cycles.
4. With outstanding=4, drive ret_valid=2'b11 with port0 tag 2 and port1 tag 0 -> port0 accepted in cycle t (pool_in=2), port1 accepted in t+1 (pool_in=0). o__outstanding goes 4->3->2.
5. With outstanding=2, a pop and a return in the same cycle -> o__outstanding stays 2. The next allocated tag is the oldest pool entry.
6. From a fresh init (outstanding=0), drive ret_valid=2'b01 -> ret_ready=0 and o__err_spurious_ret=1 from the next cycle, held until reset. After reset it is 0.

Source files
------------

// File: rtl/tag_pool_arbiter.sv
// rtl/tag_pool_arbiter.sv - Round-robin tag allocator and fixed-priority tag return merger around a shared free-list
module tag_pool_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_RET   = 2,
  parameter int TAG_WIDTH = 2,
  parameter int DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            i__alloc_req,
  output logic [NUM_REQ-1:0]            o__alloc_grant,
  output logic [TAG_WIDTH-1:0]          o__alloc_tag,
  input  logic [NUM_RET-1:0]            i__ret_valid,
  input  logic [NUM_RET*TAG_WIDTH-1:0]  i__ret_tag,
  output logic [NUM_RET-1:0]            o__ret_ready,
  input  logic                          i__pool_out_valid,
  input  logic [TAG_WIDTH-1:0]          i__pool_out,
  output logic                          o__pool_out_ready,
  output logic                          o__pool_in_valid,
  output logic [TAG_WIDTH-1:0]          o__pool_in,
  input  logic                          i__pool_in_ready,
  output logic                          o__ready,
  output logic [$clog2(DEPTH+1)-1:0]    o__outstanding,
  output logic                          o__err_spurious_ret
);
  localparam int RR_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    WAIT_INIT = 1'b0,
    ACTIVE    = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [RR_W-1:0]      rr_q, rr_d;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic                 err_q, err_d;

  logic                 active;
  logic                 have_out;
  logic [NUM_REQ-1:0]   eligible;
  logic                 win_found;
  logic [RR_W-1:0]      winner;
  logic                 pop;
  logic                 ret_any;
  logic                 ret_found;
  logic [NUM_RET-1:0]   ret_sel;
  logic [TAG_WIDTH-1:0] ret_sel_tag;
  logic                 ret_hs;

  // Two passes give "first eligible at or after rr, wrapping" without modulo index math.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && eligible[i] && (i >= int'(rr_q))) begin
        win_found = 1'b1;
        winner    = RR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && eligible[i]) begin
        win_found = 1'b1;
        winner    = RR_W'(i);
      end
    end
  end

  always_comb begin
    ret_found   = 1'b0;
    ret_sel     = '0;
    ret_sel_tag = '0;
    for (int k = 0; k < NUM_RET; k++) begin
      if (!ret_found && i__ret_valid[k]) begin
        ret_found   = 1'b1;
        ret_sel[k]  = 1'b1;
        ret_sel_tag = i__ret_tag[k*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  always_comb begin
    active   = (state_q == ACTIVE);
    have_out = (outstanding_q != '0);
    eligible = i__alloc_req & ~grant_q;
    pop      = active & i__pool_out_valid & win_found;
    ret_any  = |i__ret_valid;

    o__pool_out_ready = pop;
    o__pool_in_valid  = active & ret_any & have_out;
    o__pool_in        = active ? ret_sel_tag : '0;
    o__ret_ready      = {NUM_RET{active & have_out & i__pool_in_ready}} & ret_sel;
    ret_hs            = o__pool_in_valid & i__pool_in_ready;

    state_d = state_q;
    if (!active && i__pool_out_valid) begin
      state_d = ACTIVE;
    end

    grant_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_d[i] = pop & (winner == RR_W'(i));
    end
    tag_d = pop ? i__pool_out : tag_q;

    rr_d = rr_q;
    if (pop) begin
      rr_d = (winner == RR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

    outstanding_d = outstanding_q;
    if (pop && !ret_hs) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!pop && ret_hs) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end

    // A return while nothing is allocated can only be a protocol error upstream.
    err_d = err_q | (active & ret_any & ~have_out);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_INIT;
      grant_q       <= '0;
      tag_q         <= '0;
      rr_q          <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      tag_q         <= tag_d;
      rr_q          <= rr_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign o__alloc_grant      = grant_q;
  assign o__alloc_tag        = tag_q;
  assign o__ready            = (state_q == ACTIVE);
  assign o__outstanding      = outstanding_q;
  assign o__err_spurious_ret = err_q;

endmodule

// File: tb/tb_tag_pool_arbiter.sv
// tb/tb_tag_pool_arbiter.sv - Table, directed and randomized checks of tag_pool_arbiter with a behavioural preloaded pool
module tb_tag_pool_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int NUM_RET   = 2;
  localparam int TAG_WIDTH = 2;
  localparam int DEPTH     = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] alloc_req = '0;
  logic [3:0] alloc_grant;
  logic [1:0] alloc_tag;
  logic [1:0] ret_valid = '0;
  logic [3:0] ret_tag = '0;
  logic [1:0] ret_ready;
  logic       pool_out_valid;
  logic [1:0] pool_out;
  logic       pool_out_ready;
  logic       pool_in_valid;
  logic [1:0] pool_in;
  logic       pool_in_ready;
  logic       ready;
  logic [2:0] outstanding;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tag_pool_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_RET(NUM_RET), .TAG_WIDTH(TAG_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .i__alloc_req(alloc_req), .o__alloc_grant(alloc_grant), .o__alloc_tag(alloc_tag),
    .i__ret_valid(ret_valid), .i__ret_tag(ret_tag), .o__ret_ready(ret_ready),
    .i__pool_out_valid(pool_out_valid), .i__pool_out(pool_out), .o__pool_out_ready(pool_out_ready),
    .o__pool_in_valid(pool_in_valid), .o__pool_in(pool_in), .i__pool_in_ready(pool_in_ready),
    .o__ready(ready), .o__outstanding(outstanding), .o__err_spurious_ret(err)
  );

  // Free-list stand-in: loads tags 0..3 one per cycle after reset, then behaves as a FIFO.
  logic [1:0] pool_mem [DEPTH];
  logic [1:0] pool_rd = '0, pool_wr = '0;
  logic [2:0] pool_cnt = '0, pool_init_cnt = '0;
  logic       pool_init = 1'b1;
  logic       pool_pop, pool_push;

  assign pool_out_valid = !pool_init && (pool_cnt != 3'd0);
  assign pool_in_ready  = !pool_init && (pool_cnt < 3'd4);
  assign pool_out       = pool_mem[pool_rd];
  assign pool_pop       = pool_out_ready && pool_out_valid;
  assign pool_push      = pool_in_valid && pool_in_ready;

  always @(posedge clk) begin
    if (reset) begin
      pool_init     <= 1'b1;
      pool_init_cnt <= '0;
      pool_rd       <= '0;
      pool_wr       <= '0;
      pool_cnt      <= '0;
    end else if (pool_init) begin
      pool_mem[pool_wr] <= pool_init_cnt[1:0];
      pool_wr           <= pool_wr + 2'd1;
      pool_cnt          <= pool_cnt + 3'd1;
      pool_init_cnt     <= pool_init_cnt + 3'd1;
      if (pool_init_cnt == 3'd3) pool_init <= 1'b0;
    end else begin
      if (pool_push) begin
        pool_mem[pool_wr] <= pool_in;
        pool_wr           <= pool_wr + 2'd1;
      end
      if (pool_pop) pool_rd <= pool_rd + 2'd1;
      pool_cnt <= pool_cnt + {2'b0, pool_push} - {2'b0, pool_pop};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [1:0] rv, input logic [1:0] rt0, input logic [1:0] rt1);
    alloc_req = req;
    ret_valid = rv;
    ret_tag   = {rt1, rt0};
  endtask

  // Resets everything, checks the WAIT_INIT output gating, and leaves the bench at negedge+1 with o__ready=1.
  task automatic go_active();
    int cyc;
    reset = 1'b1;
    drive(4'b0, 2'b0, 2'd0, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    #1;
    while (!ready && cyc < 20) begin
      chk("wait_pool_out_ready", 32'(pool_out_ready), 0);
      chk("wait_pool_in_valid", 32'(pool_in_valid), 0);
      chk("wait_ret_ready", 32'(ret_ready), 0);
      chk("wait_grant", 32'(alloc_grant), 0);
      chk("wait_outstanding", 32'(outstanding), 0);
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("ready_reached", 32'(ready), 1);
    chk("ready_latency_ok", 32'(cyc >= 3 && cyc <= 8), 1);
    chk("active_outstanding", 32'(outstanding), 0);
    chk("active_err", 32'(err), 0);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [1:0] rv;
    logic [1:0] rt0;
    logic [1:0] rt1;
    logic       exp_pr;
    logic [3:0] exp_grant;
    logic [1:0] exp_tag;
    logic [2:0] exp_out;
    logic [1:0] exp_rr;
    logic       exp_piv;
    logic [1:0] exp_pin;
  } vec_t;

  vec_t vecs [10];

  int         m_active, m_rr, m_out;
  logic [3:0] m_grant;
  logic [1:0] m_tag;
  logic       m_err;

  task automatic rand_run(input int cycles);
    logic [3:0] req, elig, n_grant;
    logic [1:0] rv, last_ready, exp_rdy, n_tag;
    logic [3:0] rt_all;
    int         pend, win, selk, idx, n_rr, n_out;
    logic       exp_pop, exp_piv, n_err;
    m_active = 1; m_rr = 0; m_out = 0; m_grant = '0; m_tag = '0; m_err = 1'b0;
    rv = '0; rt_all = '0; last_ready = '0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      req = 4'($urandom_range(0, 15));
      for (int k = 0; k < NUM_RET; k++) begin
        if (rv[k] && last_ready[k]) rv[k] = 1'b0;
      end
      pend = int'(rv[0]) + int'(rv[1]);
      for (int k = 0; k < NUM_RET; k++) begin
        if (!rv[k] && (pend < m_out || $urandom_range(0, 499) == 0) && $urandom_range(0, 2) == 0) begin
          rv[k] = 1'b1;
          rt_all[k*2 +: 2] = 2'($urandom_range(0, 3));
          pend++;
        end
      end
      drive(req, rv, rt_all[1:0], rt_all[3:2]);
      #1;
      elig    = req & ~m_grant;
      exp_pop = (m_active != 0) && pool_out_valid && (elig != 4'b0);
      win = -1;
      for (int s = 0; s < NUM_REQ; s++) begin
        idx = (m_rr + s) % NUM_REQ;
        if (win < 0 && ((elig >> idx) & 4'b1) != 4'b0) win = idx;
      end
      selk = -1;
      for (int k = 0; k < NUM_RET; k++) begin
        if (selk < 0 && rv[k]) selk = k;
      end
      exp_piv = (m_active != 0) && (selk >= 0) && (m_out > 0);
      exp_rdy = (exp_piv && pool_in_ready) ? 2'(1 << selk) : 2'b0;

      chk("rnd_pool_out_ready", 32'(pool_out_ready), 32'(exp_pop));
      chk("rnd_pool_in_valid", 32'(pool_in_valid), 32'(exp_piv));
      chk("rnd_ret_ready", 32'(ret_ready), 32'(exp_rdy));
      if (exp_piv) chk("rnd_pool_in", 32'(pool_in), 32'((rt_all >> (selk * 2)) & 4'd3));
      chk("rnd_grant", 32'(alloc_grant), 32'(m_grant));
      chk("rnd_tag", 32'(alloc_tag), 32'(m_tag));
      chk("rnd_outstanding", 32'(outstanding), m_out);
      chk("rnd_err", 32'(err), 32'(m_err));
      chk("rnd_ready", 32'(ready), m_active);

      n_grant = exp_pop ? 4'(1 << win) : 4'b0;
      n_tag   = exp_pop ? pool_out : m_tag;
      n_rr    = exp_pop ? (win + 1) % NUM_REQ : m_rr;
      n_out   = m_out + (exp_pop ? 1 : 0) - ((exp_rdy != 2'b0) ? 1 : 0);
      n_err   = m_err || ((m_active != 0) && selk >= 0 && m_out == 0);
      last_ready = ret_ready;
      @(posedge clk);
      m_grant = n_grant; m_tag = n_tag; m_rr = n_rr; m_out = n_out; m_err = n_err;
    end
  endtask

  initial begin
    // Fresh init, all four requesters, then paired returns and a simultaneous pop/return.
    vecs[0] = '{4'b1111, 2'b00, 2'd0, 2'd0, 1'b1, 4'b0000, 2'd0, 3'd0, 2'b00, 1'b0, 2'd0};
    vecs[1] = '{4'b1111, 2'b00, 2'd0, 2'd0, 1'b1, 4'b0001, 2'd0, 3'd1, 2'b00, 1'b0, 2'd0};
    vecs[2] = '{4'b1111, 2'b00, 2'd0, 2'd0, 1'b1, 4'b0010, 2'd1, 3'd2, 2'b00, 1'b0, 2'd0};
    vecs[3] = '{4'b1111, 2'b00, 2'd0, 2'd0, 1'b1, 4'b0100, 2'd2, 3'd3, 2'b00, 1'b0, 2'd0};
    vecs[4] = '{4'b0000, 2'b11, 2'd2, 2'd0, 1'b0, 4'b1000, 2'd3, 3'd4, 2'b01, 1'b1, 2'd2};
    vecs[5] = '{4'b0000, 2'b10, 2'd2, 2'd0, 1'b0, 4'b0000, 2'd3, 3'd3, 2'b10, 1'b1, 2'd0};
    vecs[6] = '{4'b0001, 2'b01, 2'd3, 2'd0, 1'b1, 4'b0000, 2'd3, 3'd2, 2'b01, 1'b1, 2'd3};
    vecs[7] = '{4'b0000, 2'b00, 2'd0, 2'd0, 1'b0, 4'b0001, 2'd2, 3'd2, 2'b00, 1'b0, 2'd0};
    vecs[8] = '{4'b0010, 2'b00, 2'd0, 2'd0, 1'b1, 4'b0000, 2'd2, 3'd2, 2'b00, 1'b0, 2'd0};
    vecs[9] = '{4'b0000, 2'b00, 2'd0, 2'd0, 1'b0, 4'b0010, 2'd0, 3'd3, 2'b00, 1'b0, 2'd0};

    go_active();
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      drive(vecs[r].req, vecs[r].rv, vecs[r].rt0, vecs[r].rt1);
      #1;
      chk($sformatf("vec%0d_pool_out_ready", r), 32'(pool_out_ready), 32'(vecs[r].exp_pr));
      chk($sformatf("vec%0d_grant", r), 32'(alloc_grant), 32'(vecs[r].exp_grant));
      chk($sformatf("vec%0d_tag", r), 32'(alloc_tag), 32'(vecs[r].exp_tag));
      chk($sformatf("vec%0d_outstanding", r), 32'(outstanding), 32'(vecs[r].exp_out));
      chk($sformatf("vec%0d_ret_ready", r), 32'(ret_ready), 32'(vecs[r].exp_rr));
      chk($sformatf("vec%0d_pool_in_valid", r), 32'(pool_in_valid), 32'(vecs[r].exp_piv));
      if (vecs[r].exp_piv) chk($sformatf("vec%0d_pool_in", r), 32'(pool_in), 32'(vecs[r].exp_pin));
      chk($sformatf("vec%0d_err", r), 32'(err), 0);
    end

    // Single requester holding its request: grants on alternate cycles until the pool drains.
    go_active();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(4'b0001, 2'b00, 2'd0, 2'd0);
      #1;
      chk("hold_pool_out_ready", 32'(pool_out_ready), 32'((i % 2 == 0) && (i <= 6)));
      chk("hold_grant", 32'(alloc_grant), ((i % 2 == 1) && (i <= 7)) ? 32'd1 : 32'd0);
      if ((i % 2 == 1) && (i <= 7)) chk("hold_tag", 32'(alloc_tag), 32'((i - 1) / 2));
    end
    chk("hold_outstanding_full", 32'(outstanding), 4);

    // Requests and returns during pool initialisation must be ignored.
    reset = 1'b1;
    drive(4'b1111, 2'b11, 2'd1, 2'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("init_gate_pool_out_ready", 32'(pool_out_ready), 0);
      chk("init_gate_pool_in_valid", 32'(pool_in_valid), 0);
      chk("init_gate_ret_ready", 32'(ret_ready), 0);
      chk("init_gate_ready", 32'(ready), 0);
      chk("init_gate_err", 32'(err), 0);
      @(negedge clk);
    end

    // Spurious return with nothing outstanding: no handshake, sticky error, cleared by reset.
    go_active();
    @(negedge clk);
    drive(4'b0000, 2'b01, 2'd0, 2'd0);
    #1;
    chk("spur_ret_ready", 32'(ret_ready), 0);
    chk("spur_pool_in_valid", 32'(pool_in_valid), 0);
    chk("spur_err_before", 32'(err), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(4'b0000, 2'b00, 2'd0, 2'd0);
      #1;
      chk("spur_err_sticky", 32'(err), 1);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("spur_err_after_reset", 32'(err), 0);
    chk("reset_ready", 32'(ready), 0);
    chk("reset_outstanding", 32'(outstanding), 0);
    chk("reset_grant", 32'(alloc_grant), 0);
    chk("reset_tag", 32'(alloc_tag), 0);

    go_active();
    rand_run(1500);
    go_active();
    rand_run(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
